// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - TLB maintenance op sequencer (SRCH/RD/WR/FILL/INV) with FILL replacement counter
module tlb_op_unit #(
  parameter int  TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_type,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [18:0]   csr_ehi_vppn,
  input  logic [IW-1:0] csr_idx,
  input  logic [5:0]    csr_ps,
  input  logic          csr_ne,
  input  logic [25:0]   csr_elo0,
  input  logic [25:0]   csr_elo1,
  input  logic          csr_elo_g,
  output logic          done,
  output logic          res_hit,
  output logic [IW-1:0] res_index,
  output logic          res_ne,
  output logic [88:0]   res_entry,
  output logic          res_ine,
  output logic [18:0]   s1_vppn,
  output logic          s1_va_bit12,
  output logic [9:0]    s1_asid,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic [88:0]   tlb_w_entry,
  output logic [IW-1:0] tlb_r_index,
  input  logic [88:0]   tlb_r_entry,
  output logic          invtlb_valid,
  output logic [4:0]    invtlb_op
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    inv_op_q, inv_op_d;
  logic [9:0]    inv_asid_q, inv_asid_d;
  logic [18:0]   inv_vppn_q, inv_vppn_d;
  logic [9:0]    asid_q, asid_d;
  logic [18:0]   vppn_q, vppn_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [5:0]    ps_q, ps_d;
  logic          ne_q, ne_d;
  logic [25:0]   elo0_q, elo0_d;
  logic [25:0]   elo1_q, elo1_d;
  logic          g_q, g_d;
  logic [IW-1:0] fill_q, fill_d;
  logic          res_hit_q, res_hit_d;
  logic [IW-1:0] res_index_q, res_index_d;
  logic          res_ne_q, res_ne_d;
  logic [88:0]   res_entry_q, res_entry_d;
  logic          res_ine_q, res_ine_d;

  logic [88:0]   wr_entry;
  logic          inv_legal;

  assign wr_entry  = {~ne_q, vppn_q, ps_q, asid_q, g_q, elo0_q, elo1_q};
  assign inv_legal = (inv_op_q <= 5'd6);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    inv_op_d    = inv_op_q;
    inv_asid_d  = inv_asid_q;
    inv_vppn_d  = inv_vppn_q;
    asid_d      = asid_q;
    vppn_d      = vppn_q;
    idx_d       = idx_q;
    ps_d        = ps_q;
    ne_d        = ne_q;
    elo0_d      = elo0_q;
    elo1_d      = elo1_q;
    g_d         = g_q;
    fill_d      = fill_q;
    res_hit_d   = res_hit_q;
    res_index_d = res_index_q;
    res_ne_d    = res_ne_q;
    res_entry_d = res_entry_q;
    res_ine_d   = res_ine_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          state_d    = S_EXEC;
          op_d       = op_type;
          inv_op_d   = inv_op;
          inv_asid_d = inv_asid;
          inv_vppn_d = inv_vppn;
          asid_d     = csr_asid;
          vppn_d     = csr_ehi_vppn;
          idx_d      = csr_idx;
          ps_d       = csr_ps;
          ne_d       = csr_ne;
          elo0_d     = csr_elo0;
          elo1_d     = csr_elo1;
          g_d        = csr_elo_g;
        end
      end
      S_EXEC: begin
        // Results are rebuilt per op so stale fields from an earlier op never leak out
        state_d     = S_RESP;
        res_hit_d   = 1'b0;
        res_index_d = '0;
        res_ne_d    = 1'b0;
        res_entry_d = '0;
        res_ine_d   = 1'b0;
        case (op_q)
          OP_SRCH: begin
            res_hit_d   = s1_found;
            res_index_d = s1_found ? s1_index : '0;
            res_ne_d    = ~s1_found;
          end
          OP_RD: begin
            res_ne_d    = ~tlb_r_entry[88];
            res_entry_d = tlb_r_entry[88] ? tlb_r_entry : '0;
          end
          OP_FILL: fill_d = (fill_q == IW'(TLBNUM - 1)) ? '0 : fill_q + 1'b1;
          OP_INV:  res_ine_d = ~inv_legal;
          default: ;
        endcase
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // TLB ports are only ever non-zero in EXEC, so an async reset removes any pulse immediately
  always_comb begin
    s1_vppn      = '0;
    s1_asid      = '0;
    tlb_we       = 1'b0;
    tlb_w_index  = '0;
    tlb_w_entry  = '0;
    tlb_r_index  = '0;
    invtlb_valid = 1'b0;
    invtlb_op    = '0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_SRCH: begin
          s1_vppn = vppn_q;
          s1_asid = asid_q;
        end
        OP_RD: tlb_r_index = idx_q;
        OP_WR, OP_FILL: begin
          tlb_we      = 1'b1;
          tlb_w_index = (op_q == OP_WR) ? idx_q : fill_q;
          tlb_w_entry = wr_entry;
        end
        OP_INV: begin
          if (inv_legal) begin
            invtlb_valid = 1'b1;
            invtlb_op    = inv_op_q;
            s1_asid      = inv_asid_q;
            s1_vppn      = inv_vppn_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_ready    = (state_q == S_IDLE);
  assign done        = (state_q == S_RESP);
  assign s1_va_bit12 = 1'b0;
  assign res_hit     = res_hit_q;
  assign res_index   = res_index_q;
  assign res_ne      = res_ne_q;
  assign res_entry   = res_entry_q;
  assign res_ine     = res_ine_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_vppn_q  <= '0;
      asid_q      <= '0;
      vppn_q      <= '0;
      idx_q       <= '0;
      ps_q        <= '0;
      ne_q        <= 1'b0;
      elo0_q      <= '0;
      elo1_q      <= '0;
      g_q         <= 1'b0;
      fill_q      <= '0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
      res_ne_q    <= 1'b0;
      res_entry_q <= '0;
      res_ine_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      inv_op_q    <= inv_op_d;
      inv_asid_q  <= inv_asid_d;
      inv_vppn_q  <= inv_vppn_d;
      asid_q      <= asid_d;
      vppn_q      <= vppn_d;
      idx_q       <= idx_d;
      ps_q        <= ps_d;
      ne_q        <= ne_d;
      elo0_q      <= elo0_d;
      elo1_q      <= elo1_d;
      g_q         <= g_d;
      fill_q      <= fill_d;
      res_hit_q   <= res_hit_d;
      res_index_q <= res_index_d;
      res_ne_q    <= res_ne_d;
      res_entry_q <= res_entry_d;
      res_ine_q   <= res_ine_d;
    end
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb/tb_tlb_op_unit.sv - bench for tlb_op_unit: TLB responder, phase-level reference model, directed ops
module tb_tlb_op_unit;
  localparam int TLBNUM = 16;
  localparam int IW     = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          op_valid, op_ready;
  logic [2:0]    op_type;
  logic [4:0]    inv_op;
  logic [9:0]    inv_asid, csr_asid;
  logic [18:0]   inv_vppn, csr_ehi_vppn;
  logic [IW-1:0] csr_idx;
  logic [5:0]    csr_ps;
  logic          csr_ne, csr_elo_g;
  logic [25:0]   csr_elo0, csr_elo1;
  logic          done, res_hit, res_ne, res_ine;
  logic [IW-1:0] res_index;
  logic [88:0]   res_entry;
  logic [18:0]   s1_vppn;
  logic          s1_va_bit12;
  logic [9:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic          tlb_we;
  logic [IW-1:0] tlb_w_index, tlb_r_index;
  logic [88:0]   tlb_w_entry, tlb_r_entry;
  logic          invtlb_valid;
  logic [4:0]    invtlb_op;

  always #5 clk = ~clk;

  tlb_op_unit #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_asid(csr_asid),
    .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne),
    .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_elo_g(csr_elo_g), .done(done),
    .res_hit(res_hit), .res_index(res_index), .res_ne(res_ne), .res_entry(res_entry),
    .res_ine(res_ine), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_entry(tlb_w_entry), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op)
  );

  // TLB contents as the model believes them; the responder below answers the DUT from it
  logic [88:0] mem [TLBNUM];
  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [88:0] act, input logic [88:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IW:0] search(input logic [18:0] vppn, input logic [9:0] asid);
    logic [IW:0] r;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (mem[i][88] && mem[i][87:69] == vppn && (mem[i][52] || mem[i][62:53] == asid))
        r = {1'b1, IW'(i)};
    return r;
  endfunction

  always_comb {s1_found, s1_index} = search(s1_vppn, s1_asid);
  assign tlb_r_entry = mem[tlb_r_index];

  // Reference model: phase 0 idle, 1 TLB access, 2 result; checked on every falling edge
  int          ph = 0;
  logic [IW-1:0] mfill = '0;
  logic [2:0]  lop, rop;
  logic [4:0]  linv_op;
  logic [9:0]  linv_asid, lasid;
  logic [18:0] linv_vppn, lvppn;
  logic [IW-1:0] lidx;
  logic [5:0]  lps;
  logic        lne, lg;
  logic [25:0] lelo0, lelo1;
  logic        r_hit, r_ne, r_ine;
  logic [IW-1:0] r_index;
  logic [88:0] r_entry;

  task automatic check_res();
    chk("res_ine", 89'(res_ine), 89'(r_ine));
    if (rop == 3'd0) begin
      chk("res_hit", 89'(res_hit), 89'(r_hit));
      chk("res_index", 89'(res_index), 89'(r_index));
      chk("res_ne_srch", 89'(res_ne), 89'(r_ne));
    end else if (rop == 3'd1) begin
      chk("res_ne_rd", 89'(res_ne), 89'(r_ne));
      chk("res_entry", res_entry, r_entry);
    end
  endtask

  initial begin
    logic e_we, e_inv;
    logic [88:0] went;
    logic [IW:0] s;
    rop = 3'd7;
    {r_hit, r_ne, r_ine, r_index, r_entry} = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("rst_op_ready", 89'(op_ready), 89'(1));
        chk("rst_done", 89'(done), 89'(0));
        chk("rst_we", 89'(tlb_we), 89'(0));
        chk("rst_inv", 89'(invtlb_valid), 89'(0));
        chk("rst_res", {res_hit, res_ne, res_ine, res_index, res_entry[80:0]}, 89'(0));
        chk("rst_ports", {s1_vppn, s1_asid, tlb_w_index, tlb_r_index, invtlb_op}, 89'(0));
        ph = 0;
        mfill = '0;
        rop = 3'd7;
        {r_hit, r_ne, r_ine, r_index, r_entry} = '0;
      end else begin
        went  = {~lne, lvppn, lps, lasid, lg, lelo0, lelo1};
        e_we  = (ph == 1) && (lop == 3'd2 || lop == 3'd3);
        e_inv = (ph == 1) && (lop == 3'd4) && (linv_op <= 5'd6);
        chk("op_ready", 89'(op_ready), 89'(ph == 0));
        chk("done", 89'(done), 89'(ph == 2));
        chk("tlb_we", 89'(tlb_we), 89'(e_we));
        chk("invtlb_valid", 89'(invtlb_valid), 89'(e_inv));
        chk("va_bit12", 89'(s1_va_bit12), 89'(0));
        if (e_we) begin
          chk("w_index", 89'(tlb_w_index), 89'((lop == 3'd2) ? lidx : mfill));
          chk("w_entry", tlb_w_entry, went);
        end
        if (e_inv) begin
          chk("invtlb_op", 89'(invtlb_op), 89'(linv_op));
          chk("inv_asid", 89'(s1_asid), 89'(linv_asid));
          chk("inv_vppn", 89'(s1_vppn), 89'(linv_vppn));
        end
        if (ph == 1 && lop == 3'd0) begin
          chk("srch_vppn", 89'(s1_vppn), 89'(lvppn));
          chk("srch_asid", 89'(s1_asid), 89'(lasid));
        end
        if (ph == 1 && lop == 3'd1) chk("r_index", 89'(tlb_r_index), 89'(lidx));
        if (ph != 1) check_res();
        if (ph == 0) begin
          if (op_valid) begin
            lop = op_type; linv_op = inv_op; linv_asid = inv_asid; linv_vppn = inv_vppn;
            lasid = csr_asid; lvppn = csr_ehi_vppn; lidx = csr_idx; lps = csr_ps;
            lne = csr_ne; lelo0 = csr_elo0; lelo1 = csr_elo1; lg = csr_elo_g;
            ph = 1;
          end
        end else if (ph == 1) begin
          rop = lop;
          {r_hit, r_ne, r_index, r_entry} = '0;
          r_ine = (lop == 3'd4) && (linv_op > 5'd6);
          if (lop == 3'd0) begin
            s = search(lvppn, lasid);
            r_hit = s[IW]; r_index = s[IW-1:0]; r_ne = !s[IW];
          end else if (lop == 3'd1) begin
            r_ne = !mem[lidx][88];
            r_entry = mem[lidx][88] ? mem[lidx] : '0;
          end else if (lop == 3'd2) begin
            mem[lidx] = went;
          end else if (lop == 3'd3) begin
            mem[mfill] = went;
            mfill = IW'((int'(mfill) + 1) % TLBNUM);
          end
          ph = 2;
        end else begin
          ph = 0;
        end
      end
    end
  end

  // Observed activity, used by the hand-computed expectations in the main sequence
  int cyc = 0, acc_cyc = 0, last_lat = 0;
  int pulse_cnt = 0, inv_cnt = 0, done_cnt = 0;
  logic [4:0]  last_inv_op = '0;
  logic [9:0]  last_inv_asid = '0;
  logic [88:0] last_w_entry = '0;
  logic [IW-1:0] wq[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn) begin
        if (op_valid && op_ready) acc_cyc = cyc;
        if (done) begin last_lat = cyc - acc_cyc; done_cnt++; end
        if (tlb_we || invtlb_valid) pulse_cnt++;
        if (tlb_we) begin wq.push_back(tlb_w_index); last_w_entry = tlb_w_entry; end
        if (invtlb_valid) begin inv_cnt++; last_inv_op = invtlb_op; last_inv_asid = s1_asid; end
      end
    end
  end

  task automatic issue(input logic [2:0] t);
    op_type = t;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    {inv_op, inv_asid, inv_vppn, csr_asid, csr_ehi_vppn} = 63'({$urandom, $urandom});
    {csr_idx, csr_ps, csr_ne, csr_elo_g} = 12'($urandom);
    csr_elo0 = 26'($urandom);
    csr_elo1 = 26'($urandom);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [3:0] idx, input logic [18:0] vppn, input logic [9:0] asid,
                        input logic ne);
    csr_idx = idx; csr_ehi_vppn = vppn; csr_asid = asid; csr_ne = ne; csr_ps = 6'd12;
    csr_elo0 = 26'h1234567; csr_elo1 = 26'h0765432; csr_elo_g = 1'b0;
  endtask

  localparam logic [88:0] WR_ENT = {1'b1, 19'h12345, 6'd12, 10'h02A, 1'b0, 26'h1234567, 26'h0765432};

  initial begin
    int p0, i0, d0;
    for (int i = 0; i < TLBNUM; i++) mem[i] = '0;
    resetn = 1'b0; op_valid = 1'b0; op_type = '0;
    inv_op = '0; inv_asid = '0; inv_vppn = '0;
    set_wr(4'd0, 19'd0, 10'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    set_wr(4'd3, 19'h12345, 10'h02A, 1'b0);
    issue(3'd2);
    chk("lit_wr_latency", 89'(last_lat), 89'(2));
    chk("lit_wr_index", 89'(wq[$]), 89'(3));
    chk("lit_wr_entry", last_w_entry, WR_ENT);

    csr_ehi_vppn = 19'h12345; csr_asid = 10'h02A;
    issue(3'd0);
    chk("lit_srch_hit", 89'({res_hit, res_index, res_ne}), 89'({1'b1, 4'd3, 1'b0}));
    csr_ehi_vppn = 19'h12345; csr_asid = 10'h02B;
    issue(3'd0);
    chk("lit_srch_miss", 89'({res_hit, res_index, res_ne}), 89'({1'b0, 4'd0, 1'b1}));

    csr_idx = 4'd3;
    issue(3'd1);
    chk("lit_rd_entry", res_entry, WR_ENT);
    csr_idx = 4'd9;
    issue(3'd1);
    chk("lit_rd_empty", {res_ne, res_entry[87:0]}, {1'b1, 88'd0});
    set_wr(4'd5, 19'h00ABC, 10'h011, 1'b1);
    issue(3'd2);
    csr_idx = 4'd5;
    issue(3'd1);
    chk("lit_rd_ne_entry", {res_ne, res_entry[87:0]}, {1'b1, 88'd0});

    i0 = inv_cnt;
    inv_op = 5'd5; inv_asid = 10'd7; inv_vppn = 19'h12345;
    issue(3'd4);
    chk("lit_inv_pulses", 89'(inv_cnt - i0), 89'(1));
    chk("lit_inv_op", 89'({last_inv_op, last_inv_asid}), 89'({5'd5, 10'd7}));
    p0 = pulse_cnt;
    inv_op = 5'd9;
    issue(3'd4);
    chk("lit_inv9_pulses", 89'(pulse_cnt - p0), 89'(0));
    chk("lit_inv9_ine", 89'(res_ine), 89'(1));
    p0 = pulse_cnt; d0 = done_cnt;
    issue(3'd6);
    chk("lit_rsvd", 89'({pulse_cnt - p0, done_cnt - d0}), 89'({32'd0, 32'd1}));

    wq.delete();
    for (int k = 0; k < 17; k++) begin
      set_wr(4'd0, 19'(k), 10'(k), 1'b0);
      issue(3'd3);
    end
    chk("lit_fill_count", 89'(wq.size()), 89'(17));
    for (int k = 0; k < 17 && k < wq.size(); k++)
      chk($sformatf("lit_fill_idx%0d", k), 89'(wq[k]), 89'(k % 16));

    repeat (3) issue(3'd3);
    op_type = 3'd3; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    wq.delete();
    issue(3'd3);
    chk("lit_fill_after_rst", 89'({wq.size() == 1, (wq.size() > 0) ? wq[0] : 4'hF}), 89'({1'b1, 4'd0}));

    p0 = pulse_cnt; d0 = done_cnt;
    set_wr(4'd7, 19'h00777, 10'h077, 1'b0);
    op_type = 3'd2; op_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_thru_pulses", 89'(pulse_cnt - p0), 89'(4));
    chk("lit_thru_dones", 89'(done_cnt - d0), 89'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
